j4_uart: RTL and testbench

Memory-mapped 8N1 UART peripheral that is the responder end of the j4 core's IO port (`io_we`, `io_re`, `io_ptr`, data in both directions). It decodes core IO writes into a transmit holding register and serializer, and presents a receive buffer and status word on core IO reads. It sits beside the j4 core at top level, with its `io_in` driven by the core's `io_out` and its `io_out` feeding the core's `io_in`.

---
 rtl/j4_uart.sv | 198 +++++++++++++++++++
 tb/tb_j4_uart.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/j4_uart.sv
// Memory-mapped 8N1 UART responding on the j4 core IO port: TX holding register and serializer,
// RX deserializer with status flags (valid, overrun, framing error).
`timescale 1ns/1ps
module j4_uart #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] BASE         = 16'h7000,
  parameter int               CLKS_PER_BIT = 434
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             io_we,
  input  logic             io_re,
  input  logic [WIDTH-1:0] io_ptr,
  input  logic [WIDTH-1:0] io_in,
  output logic [WIDTH-1:0] io_out,
  input  logic             uart_rx,
  output logic             uart_tx
);

  localparam int               CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]    BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]    HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [WIDTH-1:0] ADDR_STAT = BASE + WIDTH'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_idx, tx_idx_n;
  logic [7:0]    tx_shift, tx_shift_n;
  logic          tx_line_n, tx_busy, tx_start, tx_last;

  state_t        rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_idx, rx_idx_n;
  logic [7:0]    rx_shift, rx_shift_n;
  logic          rx_s1, rx_s2, rx_prev, rx_done, rx_last;

  logic [7:0]    rx_byte;
  logic          rx_valid, rx_overrun, frame_err;
  logic          wr_data, wr_ctrl, rd_data, rx_load, ovr_set, fe_set;

  // Upper write-data bits carry nothing for this peripheral.
  logic unused_io_in;
  assign unused_io_in = ^io_in[WIDTH-1:8];

  assign wr_data = io_we && (io_ptr == BASE);
  assign wr_ctrl = io_we && (io_ptr == ADDR_STAT);
  assign rd_data = io_re && (io_ptr == BASE);

  always_comb begin
    io_out = '0;
    if (io_re) begin
      if (io_ptr == BASE)           io_out[7:0] = rx_byte;
      else if (io_ptr == ADDR_STAT) io_out[3:0] = {frame_err, rx_overrun, rx_valid, tx_busy};
    end
  end

  assign tx_busy  = (tx_state != IDLE);
  assign tx_last  = (tx_cnt == BIT_LAST);
  // Accepting in the last stop-bit cycle gives back-to-back frames without an idle gap.
  assign tx_start = wr_data && ((tx_state == IDLE) || ((tx_state == STOP) && tx_last));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      uart_tx  <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_idx   <= tx_idx_n;
      tx_shift <= tx_shift_n;
      uart_tx  <= tx_line_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + 1'b1;
    tx_idx_n   = tx_idx;
    tx_shift_n = tx_shift;
    tx_line_n  = uart_tx;
    case (tx_state)
      IDLE: begin
        tx_cnt_n  = '0;
        tx_line_n = 1'b1;
      end
      START: if (tx_last) begin
        tx_state_n = DATA;
        tx_cnt_n   = '0;
        tx_idx_n   = '0;
        tx_line_n  = tx_shift[0];
      end
      DATA: if (tx_last) begin
        tx_cnt_n = '0;
        if (tx_idx == 3'd7) begin
          tx_state_n = STOP;
          tx_line_n  = 1'b1;
        end else begin
          tx_idx_n   = tx_idx + 3'd1;
          tx_shift_n = {1'b0, tx_shift[7:1]};
          tx_line_n  = tx_shift[1];
        end
      end
      STOP: if (tx_last) begin
        tx_state_n = IDLE;
        tx_cnt_n   = '0;
      end
      default: tx_state_n = IDLE;
    endcase
    if (tx_start) begin
      tx_state_n = START;
      tx_cnt_n   = '0;
      tx_shift_n = io_in[7:0];
      tx_line_n  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else begin
      rx_s1    <= uart_rx;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_idx   <= rx_idx_n;
      rx_shift <= rx_shift_n;
    end
  end

  assign rx_last = (rx_cnt == BIT_LAST);

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + 1'b1;
    rx_idx_n   = rx_idx;
    rx_shift_n = rx_shift;
    rx_done    = 1'b0;
    case (rx_state)
      IDLE: begin
        rx_cnt_n = '0;
        if (rx_prev && !rx_s2) rx_state_n = START;
      end
      // Half-bit wait re-checks the start bit so short glitches are rejected.
      START: if (rx_cnt == HALF_LAST) begin
        rx_cnt_n   = '0;
        rx_idx_n   = '0;
        rx_state_n = rx_s2 ? IDLE : DATA;
      end
      DATA: if (rx_last) begin
        rx_cnt_n   = '0;
        rx_shift_n = {rx_s2, rx_shift[7:1]};
        if (rx_idx == 3'd7) rx_state_n = STOP;
        else                rx_idx_n   = rx_idx + 3'd1;
      end
      STOP: if (rx_last) begin
        rx_cnt_n   = '0;
        rx_done    = 1'b1;
        rx_state_n = IDLE;
      end
      default: rx_state_n = IDLE;
    endcase
  end

  // A data read at the completion edge frees the buffer, so the new byte loads without overrun.
  assign rx_load = rx_done && rx_s2 && (!rx_valid || rd_data);
  assign ovr_set = rx_done && rx_s2 && rx_valid && !rd_data;
  assign fe_set  = rx_done && !rx_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_byte    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (rx_load) rx_byte <= rx_shift;
      if (rx_load)      rx_valid <= 1'b1;
      else if (rd_data) rx_valid <= 1'b0;
      if (ovr_set)                     rx_overrun <= 1'b1;
      else if (wr_ctrl && io_in[2])    rx_overrun <= 1'b0;
      if (fe_set)                      frame_err  <= 1'b1;
      else if (wr_ctrl && io_in[3])    frame_err  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_j4_uart.sv
// Scoreboard bench for j4_uart: expected TX bytes and register reads are queued with the stimulus
// and retired by the serial-line monitor and the IO read task.
`timescale 1ns/1ps
module tb_j4_uart;
  localparam int          CPB  = 4;
  localparam logic [15:0] BASE = 16'h7000;
  localparam logic [15:0] STAT = 16'h7001;

  logic        clk = 1'b0, rst_n = 1'b0, io_we = 1'b0, io_re = 1'b0;
  logic [15:0] io_ptr = '0, io_in = '0, io_out;
  logic        uart_tx, uart_rx, rx_drv = 1'b1, loop_en = 1'b0;
  logic [15:0] rd;
  logic [7:0]  mb, mexp;
  bit          mon_en = 1'b1;
  int          n_chk = 0, n_fail = 0, frames = 0, f0;

  typedef struct {string tag; logic [15:0] val;} exp_t;
  exp_t       rd_q[$];
  exp_t       e;
  logic [7:0] tx_q[$];

  assign uart_rx = loop_en ? uart_tx : rx_drv;
  always #5 clk = ~clk;

  j4_uart #(.WIDTH(16), .BASE(BASE), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .io_we(io_we), .io_re(io_re), .io_ptr(io_ptr),
    .io_in(io_in), .io_out(io_out), .uart_rx(uart_rx), .uart_tx(uart_tx)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic io_write(input logic [15:0] addr, input logic [15:0] data);
    @(negedge clk);
    io_we = 1'b1; io_ptr = addr; io_in = data;
    @(negedge clk);
    io_we = 1'b0;
  endtask

  task automatic io_read(input logic [15:0] addr, output logic [15:0] data);
    @(negedge clk);
    io_re = 1'b1; io_ptr = addr;
    #1 data = io_out;
    @(negedge clk);
    io_re = 1'b0;
  endtask

  task automatic expect_rd(input string tag, input logic [15:0] val);
    exp_t x;
    x.tag = tag; x.val = val;
    rd_q.push_back(x);
  endtask

  task automatic read_chk(input logic [15:0] addr);
    io_read(addr, rd);
    if (rd_q.size() == 0) begin
      $display("FAIL rd_q: read of %0h with no expected value queued", addr);
      $fatal(1);
    end
    e = rd_q.pop_front();
    check_eq(e.tag, rd, e.val);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_drv = stop;
    repeat (CPB) @(negedge clk);
    rx_drv = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Serial-line monitor: samples mid-bit and retires the oldest expected TX byte.
  initial forever begin
    @(negedge clk);
    if (mon_en && rst_n && uart_tx === 1'b0) begin
      repeat (CPB / 2) @(negedge clk);
      check_eq("tx_start_bit", uart_tx, 0);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        mb[i] = uart_tx;
      end
      repeat (CPB) @(negedge clk);
      check_eq("tx_stop_bit", uart_tx, 1);
      frames++;
      check_eq("tx_frame_expected", 32'(tx_q.size() != 0), 1);
      if (tx_q.size() != 0) begin
        mexp = tx_q.pop_front();
        check_eq("tx_byte", mb, mexp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check_eq("tx_idle_in_reset", uart_tx, 1);
    rst_n = 1'b1;
    expect_rd("stat_after_reset", 16'h0000);
    read_chk(STAT);
    expect_rd("data_after_reset", 16'h0000);
    read_chk(BASE);
    check_eq("tx_idle_after_reset", uart_tx, 1);

    // single frame, busy window exactly 10 bit times
    tx_q.push_back(8'hA5);
    io_write(BASE, 16'h00A5);
    repeat (9) @(negedge clk);
    expect_rd("busy_mid_frame", 16'h0001);
    read_chk(STAT);
    repeat (27) @(negedge clk);
    expect_rd("busy_last_cycle", 16'h0001);
    read_chk(STAT);
    expect_rd("idle_after_frame", 16'h0000);
    read_chk(STAT);
    repeat (4) @(negedge clk);

    // write while busy is dropped
    f0 = frames;
    tx_q.push_back(8'hA5);
    io_write(BASE, 16'h00A5);
    repeat (6) @(negedge clk);
    io_write(BASE, 16'h0011);
    repeat (60) @(negedge clk);
    check_eq("one_frame_only", frames - f0, 1);

    // loopback receive
    loop_en = 1'b1;
    tx_q.push_back(8'h3C);
    io_write(BASE, 16'h003C);
    repeat (50) @(negedge clk);
    expect_rd("loop_stat", 16'h0002);
    read_chk(STAT);
    expect_rd("loop_data", 16'h003C);
    read_chk(BASE);
    expect_rd("loop_stat_cleared", 16'h0000);
    read_chk(STAT);
    loop_en = 1'b0;

    // overrun
    send_rx(8'h55, 1'b1);
    send_rx(8'hAA, 1'b1);
    @(negedge clk);
    io_ptr = STAT; io_re = 1'b0;
    #1 check_eq("io_out_no_read", io_out, 16'h0000);
    expect_rd("overrun_stat", 16'h0006);
    read_chk(STAT);
    io_write(STAT, 16'h0004);
    expect_rd("overrun_cleared", 16'h0002);
    read_chk(STAT);
    expect_rd("overrun_kept_first", 16'h0055);
    read_chk(BASE);
    expect_rd("stat_all_clear", 16'h0000);
    read_chk(STAT);

    // framing error
    send_rx(8'h81, 1'b0);
    expect_rd("frame_err_stat", 16'h0008);
    read_chk(STAT);
    io_write(STAT, 16'h0008);
    expect_rd("frame_err_cleared", 16'h0000);
    read_chk(STAT);

    // one-cycle glitch is a false start
    @(negedge clk);
    rx_drv = 1'b0;
    @(negedge clk);
    rx_drv = 1'b1;
    repeat (12) @(negedge clk);
    expect_rd("glitch_stat", 16'h0000);
    read_chk(STAT);
    expect_rd("glitch_byte_kept", 16'h0055);
    read_chk(BASE);

    // reset mid-frame forces the line idle at once
    mon_en = 1'b0;
    io_write(BASE, 16'h0000);
    repeat (10) @(negedge clk);
    #1 check_eq("tx_low_mid_frame", uart_tx, 0);
    #1 rst_n = 1'b0;
    #1 check_eq("tx_high_async_reset", uart_tx, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expect_rd("stat_after_abort", 16'h0000);
    read_chk(STAT);
    expect_rd("data_after_abort", 16'h0000);
    read_chk(BASE);
    check_eq("tx_idle_after_abort", uart_tx, 1);

    check_eq("tx_q_drained", tx_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
